// File: rtl/vertex_transform_engine.sv
// Sequential y = M*v transform stage: one MAC lane per output row, one matrix column per cycle.
// M lives in an internal register file (identity after reset), vectors use valid/ready handshakes.
module vertex_transform_engine #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_we,
  input  logic [$clog2(N)-1:0]  m_row,
  input  logic [$clog2(N)-1:0]  m_col,
  input  logic [DATA_W-1:0]     m_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DATA_W-1:0]   out_vec,
  output logic                  busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned RW = ACC_W + 1;
  localparam logic [IW-1:0]         KLast   = IW'(N - 1);
  localparam logic [DATA_W-1:0]     One     = DATA_W'(longint'(1) << FRAC_W);
  localparam logic signed [RW-1:0]  RndHalf = RW'(longint'(1) << (FRAC_W - 1));
  localparam logic signed [RW-1:0]  SatMax  = RW'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [RW-1:0]  SatMin  = ~SatMax;

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e state_q, state_d;

  logic [IW-1:0]              k_q;
  logic signed [ACC_W-1:0]    acc_q [N];
  logic signed [ACC_W-1:0]    acc_d [N];
  logic signed [DATA_W-1:0]   vec_q [N];
  logic signed [DATA_W-1:0]   mat_q [N][N];
  logic [N*DATA_W-1:0]        out_vec_q;
  logic                       out_valid_q;
  logic [N*DATA_W-1:0]        sat_vec;
  logic                       accept;
  logic                       last_col;
  logic                       m_hit;

  assign accept   = (state_q == StIdle) && in_valid;
  assign last_col = (k_q == KLast);
  // Writes outside IDLE are dropped so an in-flight vector sees one consistent M.
  assign m_hit    = (state_q == StIdle) && m_we && (32'(m_row) < N) && (32'(m_col) < N);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid)  state_d = StCompute;
      StCompute: if (last_col)  state_d = StOutput;
      StOutput:  if (out_ready) state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = out_valid_q;
    out_vec   = out_vec_q;
  end

  // Per-lane MAC for the current column, plus round-half-up and saturation of the updated sum.
  always_comb begin
    logic signed [2*DATA_W-1:0] prod;
    logic signed [RW-1:0]       rnd;
    prod    = '0;
    rnd     = '0;
    sat_vec = '0;
    for (int r = 0; r < N; r++) begin
      prod     = mat_q[r][k_q] * vec_q[k_q];
      acc_d[r] = acc_q[r] + ACC_W'(prod);
      rnd      = (RW'(acc_d[r]) + RndHalf) >>> FRAC_W;
      if (rnd > SatMax) begin
        sat_vec[r*DATA_W +: DATA_W] = SatMax[DATA_W-1:0];
      end else if (rnd < SatMin) begin
        sat_vec[r*DATA_W +: DATA_W] = SatMin[DATA_W-1:0];
      end else begin
        sat_vec[r*DATA_W +: DATA_W] = rnd[DATA_W-1:0];
      end
    end
  end

  // Matrix register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= (r == c) ? One : '0;
        end
      end
    end else if (m_hit) begin
      mat_q[m_row][m_col] <= m_data;
    end
  end

  // Datapath: vector latch, accumulators, column counter, registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        acc_q[r] <= '0;
        vec_q[r] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            k_q <= '0;
            for (int r = 0; r < N; r++) begin
              acc_q[r] <= '0;
              vec_q[r] <= in_vec[r*DATA_W +: DATA_W];
            end
          end
        end
        StCompute: begin
          k_q <= k_q + 1'b1;
          for (int r = 0; r < N; r++) begin
            acc_q[r] <= acc_d[r];
          end
          // Result is registered on the same edge as the final column update.
          if (last_col) begin
            out_vec_q   <= sat_vec;
            out_valid_q <= 1'b1;
          end
        end
        StOutput: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_transform_engine.sv
// Scoreboard bench for vertex_transform_engine: a plain-arithmetic model of y = sat(round(M*v))
// queues expected results at each accept, and a monitor compares them on each output handshake.
module tb_vertex_transform_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_we = 1'b0;
  logic [1:0]    m_row = '0;
  logic [1:0]    m_col = '0;
  logic [DW-1:0] m_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_vec;
  logic          busy;

  int            checks = 0;
  int            failures = 0;
  logic [VW-1:0] exp_q[$];
  int            model_m[N][N];

  vertex_transform_engine #(
    .N      (N),
    .DATA_W (DW),
    .FRAC_W (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_we      (m_we),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_data    (m_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: exact integer dot products, floor((s + half) / 2^FW), clamp to the element range.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
    logic [VW-1:0] res;
    longint        s;
    res = '0;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) begin
        s += longint'(model_m[r][c]) * longint'($signed(v[c*DW +: DW]));
      end
      s = (s + (longint'(1) << (FW - 1))) >>> FW;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      res[r*DW +: DW] = s[DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [VW-1:0] v;
    v = {16'(d), 16'(c), 16'(b), 16'(a)};
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    logic [DW-1:0] e;
    if ($urandom_range(0, 1) == 1) e = 16'($urandom);
    else e = 16'($urandom_range(0, 2047)) - 16'd1024;
    return e;
  endfunction

  task automatic model_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model_m[r][c] = (r == c) ? (1 << FW) : 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller guarantees the engine is idle.
  task automatic mwrite(input int r, input int c, input logic [DW-1:0] d);
    m_we   = 1'b1;
    m_row  = 2'(r);
    m_col  = 2'(c);
    m_data = d;
    step();
    m_we   = 1'b0;
    model_m[r][c] = int'($signed(d));
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", exp_q.size());
    end
  endtask

  // Present v until accepted; optionally write M in the accept cycle (it must be visible).
  task automatic send(input logic [VW-1:0] v, input bit wr, input int r, input int c,
                      input logic [DW-1:0] d, input bit rnd_rdy, output int waits);
    in_vec   = v;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 300) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      step();
      waits++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready expected=ready");
      in_valid = 1'b0;
      return;
    end
    if (wr) begin
      m_we   = 1'b1;
      m_row  = 2'(r);
      m_col  = 2'(c);
      m_data = d;
      model_m[r][c] = int'($signed(d));
    end
    exp_q.push_back(model(v));
    step();
    in_valid = 1'b0;
    m_we     = 1'b0;
  endtask

  // Monitor: a handshake completes at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", out_vec);
      end else begin
        check("out_vec", out_vec, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            waits;
    int            edges;
    int            busy_low;
    int            ov_seen;
    logic [VW-1:0] v;
    logic [VW-1:0] exp5;

    model_identity();
    @(negedge clk);
    check("reset_out_valid", VW'(out_valid), '0);
    check("reset_busy", VW'(busy), '0);
    check("reset_out_vec", out_vec, '0);
    step();
    rst = 1'b0;
    step();
    check("reset_in_ready", VW'(in_ready), VW'(1));

    // 1: identity pass-through, latency and busy window
    send(pack4('h100, 'h200, 'h300, 'h400), 1'b0, 0, 0, '0, 1'b0, waits);
    check("busy_after_accept", VW'(busy), VW'(1));
    edges    = 0;
    busy_low = 0;
    while (edges < 20) begin
      @(negedge clk);
      if (out_valid) break;
      if (!busy) busy_low++;
      edges++;
      @(posedge clk);
    end
    check("latency_edges", VW'(edges), VW'(N));
    check("busy_low_in_compute", VW'(busy_low), '0);
    check("busy_in_output", VW'(busy), VW'(1));
    #1;
    drain();
    check("identity_result_model", model(pack4('h100, 'h200, 'h300, 'h400)),
          pack4('h100, 'h200, 'h300, 'h400));

    // 2: all elements 0.5
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mwrite(r, c, 16'h0080);
    send(pack4('h100, 'h200, 'h300, 'h400), 1'b0, 0, 0, '0, 1'b0, waits);
    drain();

    // 3: positive and negative saturation
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mwrite(r, c, 16'h7f00);
    send(pack4('h7f00, 'h7f00, 'h7f00, 'h7f00), 1'b0, 0, 0, '0, 1'b0, waits);
    send(pack4('h8100, 'h8100, 'h8100, 'h8100), 1'b0, 0, 0, '0, 1'b0, waits);
    drain();

    // 4: round-half-up on a 0.5 diagonal
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mwrite(r, c, (r == c) ? 16'h0080 : 16'h0000);
    send(pack4('h0001, 'hffff, 'h0003, 'h0000), 1'b0, 0, 0, '0, 1'b0, waits);
    drain();

    // 5: backpressure, dropped write, held input
    out_ready = 1'b0;
    v    = pack4('h100, 'hff00, 'h280, 'h040);
    exp5 = model(v);
    send(v, 1'b0, 0, 0, '0, 1'b0, waits);
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check("bp_out_valid", VW'(out_valid), VW'(1));
    v = pack4('h300, 'h100, 'hfe00, 'h080);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_vec   = v;
      m_we     = 1'b1;
      m_row    = 2'd0;
      m_col    = 2'd0;
      m_data   = 16'h0000;
      @(negedge clk);
      check("bp_out_vec_stable", out_vec, exp5);
      check("bp_in_ready_low", VW'(in_ready), '0);
      step();
    end
    m_we      = 1'b0;
    out_ready = 1'b1;
    send(v, 1'b0, 0, 0, '0, 1'b0, waits);
    check("bp_idle_next_cycle", VW'(waits), VW'(1));
    drain();

    // 6: reset in the second compute cycle
    v = pack4('h1234, 'h0456, 'hf789, 'h0abc);
    send(v, 1'b0, 0, 0, '0, 1'b0, waits);
    step();
    rst = 1'b1;
    exp_q.delete();
    model_identity();
    step();
    rst = 1'b0;
    ov_seen  = 0;
    busy_low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
      if (!busy) busy_low++;
      @(posedge clk);
    end
    #1;
    check("abort_no_out_valid", VW'(ov_seen), '0);
    check("abort_busy_low", VW'(busy_low), VW'(8));
    check("abort_in_ready", VW'(in_ready), VW'(1));
    send(v, 1'b0, 0, 0, '0, 1'b0, waits);
    drain();

    // Randomized traffic with random M updates and random backpressure
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        drain();
        for (int j = 0; j < 4; j++)
          mwrite($urandom_range(0, N - 1), $urandom_range(0, N - 1), rand_elem());
      end
      v = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
      send(v, ($urandom_range(0, 3) == 0), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
           rand_elem(), 1'b1, waits);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
